// File: rtl/contour_pkg.sv
// Shared definitions for the contour bin reader slice.
// Holds the image geometry, bus widths, the per-bin statistics record
// and the reader state encoding. These are used by the reader top level
// and by the per-bin accumulator.
package contour_pkg;

  localparam int WIDTH        = 640;
  localparam int HEIGHT       = 480;
  localparam int READ_LATENCY = 2;
  localparam int NUM_BINS     = 7;

  localparam int ADDR_W = 19;
  localparam int BIN_W  = 3;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;

  // Statistics gathered for one bin label during a scan.
  typedef struct packed {
    logic [ADDR_W-1:0] count;
    logic [X_W-1:0]    x_min;
    logic [X_W-1:0]    x_max;
    logic [Y_W-1:0]    y_min;
    logic [Y_W-1:0]    y_max;
  } bin_stats_t;

  // Minimums start at all-ones so the first hit always replaces them.
  localparam bin_stats_t STATS_INIT = '{
    count: '0,
    x_min: '1,
    x_max: '0,
    y_min: '1,
    y_max: '0
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_EMIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/contour_bin_reader_bin_stats_accum.sv
// Per-bin statistics accumulator.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : restarts the statistics for a new scan
//   hit        : the current returned pixel belongs to this bin
//   x, y       : coordinates of the current returned pixel
//   stats      : pixel count (saturating) and bounding box of the bin
module bin_stats_accum
  import contour_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           hit,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output bin_stats_t     stats
);

  // Count saturates rather than wrapping so an oversize image can never
  // report a small, misleading count.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      stats <= STATS_INIT;
    end else if (hit) begin
      if (stats.count != '1) begin
        stats.count <= stats.count + ADDR_W'(1);
      end
      if (x < stats.x_min) stats.x_min <= x;
      if (x > stats.x_max) stats.x_max <= x;
      if (y < stats.y_min) stats.y_min <= y;
      if (y > stats.y_max) stats.y_max <= y;
    end
  end

endmodule

// File: rtl/contour_bin_reader.sv
// Contour bin reader: raster-scans the 3-bit bin BRAM once, gathers
// per-bin pixel count and bounding box, then streams one record per bin
// (labels 1..NUM_BINS, empty bins included) over a valid/ready handshake.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   start           : pulse, begins a scan from IDLE or DONE
//   busy, done      : scan/emit in progress, results all delivered
//   edge_addr_read  : row-major BRAM read address
//   bram_read       : BRAM data, READ_LATENCY cycles after the address
//   bin_valid/ready : record handshake
//   bin_id ... bin_y_max : record fields; empty bins report all zeros
module contour_bin_reader
  import contour_pkg::*;
#(
  parameter int WIDTH        = contour_pkg::WIDTH,
  parameter int HEIGHT       = contour_pkg::HEIGHT,
  parameter int READ_LATENCY = contour_pkg::READ_LATENCY,
  parameter int NUM_BINS     = contour_pkg::NUM_BINS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] edge_addr_read,
  input  logic [BIN_W-1:0]  bram_read,
  output logic              bin_valid,
  input  logic              bin_ready,
  output logic [BIN_W-1:0]  bin_id,
  output logic              bin_present,
  output logic [ADDR_W-1:0] bin_count,
  output logic [X_W-1:0]    bin_x_min,
  output logic [X_W-1:0]    bin_x_max,
  output logic [Y_W-1:0]    bin_y_min,
  output logic [Y_W-1:0]    bin_y_max
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [X_W-1:0]    LAST_X     = X_W'(WIDTH - 1);
  localparam logic [BIN_W-1:0]  LAST_BIN   = BIN_W'(NUM_BINS);
  localparam logic [3:0]        DRAIN_LAST = 4'(READ_LATENCY - 1);

  state_t              state;
  state_t              state_next;
  logic                accept_start;
  logic [X_W-1:0]      x_cnt;
  logic [Y_W-1:0]      y_cnt;
  logic [3:0]          drain_cnt;
  logic [BIN_W-1:0]    emit_idx;

  logic [READ_LATENCY-1:0] vld_pipe;
  logic [X_W-1:0]          x_pipe [READ_LATENCY];
  logic [Y_W-1:0]          y_pipe [READ_LATENCY];

  bin_stats_t stats [1:NUM_BINS];
  bin_stats_t sel;

  // A start is only honoured when no scan is in flight.
  assign accept_start = start && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (accept_start) state_next = ST_SCAN;
      ST_SCAN:          if (edge_addr_read == LAST_ADDR) state_next = ST_DRAIN;
      ST_DRAIN:         if (drain_cnt == DRAIN_LAST) state_next = ST_EMIT;
      ST_EMIT:          if (bin_ready && (emit_idx == LAST_BIN)) state_next = ST_DONE;
      default:          state_next = ST_IDLE;
    endcase
  end

  // Address and coordinate generation. The address is held on the last
  // pixel through DRAIN; drain_cnt and emit_idx are primed while scanning
  // so they are ready the moment their state is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_addr_read <= '0;
      x_cnt          <= '0;
      y_cnt          <= '0;
      drain_cnt      <= '0;
      emit_idx       <= BIN_W'(1);
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (accept_start) begin
            edge_addr_read <= '0;
            x_cnt          <= '0;
            y_cnt          <= '0;
          end
        end
        ST_SCAN: begin
          drain_cnt <= '0;
          emit_idx  <= BIN_W'(1);
          if (edge_addr_read != LAST_ADDR) begin
            edge_addr_read <= edge_addr_read + ADDR_W'(1);
            if (x_cnt == LAST_X) begin
              x_cnt <= '0;
              y_cnt <= y_cnt + Y_W'(1);
            end else begin
              x_cnt <= x_cnt + X_W'(1);
            end
          end
        end
        ST_DRAIN: drain_cnt <= drain_cnt + 4'(1);
        ST_EMIT: begin
          if (bin_ready && (emit_idx != LAST_BIN)) emit_idx <= emit_idx + BIN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Coordinate delay line: the tail entry lines up with the BRAM word
  // returning this cycle. Only the valid flags need clearing on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= (state == ST_SCAN);
      for (int i = 1; i < READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
    x_pipe[0] <= x_cnt;
    y_pipe[0] <= y_cnt;
    for (int i = 1; i < READ_LATENCY; i++) begin
      x_pipe[i] <= x_pipe[i-1];
      y_pipe[i] <= y_pipe[i-1];
    end
  end

  for (genvar g = 1; g <= NUM_BINS; g++) begin : g_bin
    bin_stats_accum u_accum (
      .clk   (clk),
      .reset (reset),
      .clear (accept_start),
      .hit   (vld_pipe[READ_LATENCY-1] && (bram_read == BIN_W'(g))),
      .x     (x_pipe[READ_LATENCY-1]),
      .y     (y_pipe[READ_LATENCY-1]),
      .stats (stats[g])
    );
  end

  // Status and record mux. Outside EMIT every record field reads zero, and
  // an empty bin reports zero bounds rather than its all-ones minimums.
  always_comb begin
    sel         = '0;
    busy        = (state == ST_SCAN) || (state == ST_DRAIN) || (state == ST_EMIT);
    done        = (state == ST_DONE);
    bin_valid   = 1'b0;
    bin_id      = '0;
    bin_present = 1'b0;
    bin_count   = '0;
    bin_x_min   = '0;
    bin_x_max   = '0;
    bin_y_min   = '0;
    bin_y_max   = '0;
    for (int i = 1; i <= NUM_BINS; i++) begin
      if (emit_idx == BIN_W'(i)) sel = stats[i];
    end
    if (state == ST_EMIT) begin
      bin_valid = 1'b1;
      bin_id    = emit_idx;
      if (sel.count != '0) begin
        bin_present = 1'b1;
        bin_count   = sel.count;
        bin_x_min   = sel.x_min;
        bin_x_max   = sel.x_max;
        bin_y_min   = sel.y_min;
        bin_y_max   = sel.y_max;
      end
    end
  end

endmodule

// File: tb/tb_contour_bin_reader.sv
// Testbench for contour_bin_reader on a reduced 64x48 image.
// A BRAM model with a two-cycle read feeds the reader; expected records
// come from a whole-image sweep of the same memory contents.
module tb_contour_bin_reader;

  localparam int W  = 64;
  localparam int H  = 48;
  localparam int N  = W * H;
  localparam int NB = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [18:0] edge_addr_read;
  logic [2:0]  bram_read;
  logic        bin_valid;
  logic        bin_ready;
  logic [2:0]  bin_id;
  logic        bin_present;
  logic [18:0] bin_count;
  logic [9:0]  bin_x_min;
  logic [9:0]  bin_x_max;
  logic [8:0]  bin_y_min;
  logic [8:0]  bin_y_max;

  logic [2:0] mem [N];
  logic [2:0] rd1;
  logic [2:0] rd2;

  int tests_run    = 0;
  int tests_failed = 0;
  int busy_cnt     = 0;

  int exp_cnt  [8];
  int exp_xmin [8];
  int exp_xmax [8];
  int exp_ymin [8];
  int exp_ymax [8];

  contour_bin_reader #(
    .WIDTH        (W),
    .HEIGHT       (H),
    .READ_LATENCY (2),
    .NUM_BINS     (NB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .edge_addr_read (edge_addr_read),
    .bram_read      (bram_read),
    .bin_valid      (bin_valid),
    .bin_ready      (bin_ready),
    .bin_id         (bin_id),
    .bin_present    (bin_present),
    .bin_count      (bin_count),
    .bin_x_min      (bin_x_min),
    .bin_x_max      (bin_x_max),
    .bin_y_min      (bin_y_min),
    .bin_y_max      (bin_y_max)
  );

  always #5 clk = ~clk;

  // Two-cycle BRAM: data for the address seen at one edge appears two
  // edges later.
  always @(posedge clk) begin
    rd1 <= mem[int'(edge_addr_read)];
    rd2 <= rd1;
  end
  assign bram_read = rd2;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clearMem();
    for (int a = 0; a < N; a++) mem[a] = 3'd0;
  endtask

  task automatic setPix(input int x, input int y, input int v);
    mem[y * W + x] = 3'(v);
  endtask

  task automatic randomImage(input int pixels);
    clearMem();
    for (int k = 0; k < pixels; k++) mem[$urandom_range(0, N - 1)] = 3'($urandom_range(0, 7));
  endtask

  // Reference: sweep the whole image and fold every labelled pixel into
  // its bin; empty bins report all-zero bounds.
  task automatic computeExpected();
    for (int b = 0; b <= NB; b++) begin
      exp_cnt[b] = 0; exp_xmin[b] = W; exp_xmax[b] = 0; exp_ymin[b] = H; exp_ymax[b] = 0;
    end
    for (int a = 0; a < N; a++) begin
      int v;
      v = int'(mem[a]);
      if (v >= 1 && v <= NB) begin
        exp_cnt[v]++;
        if (a % W < exp_xmin[v]) exp_xmin[v] = a % W;
        if (a % W > exp_xmax[v]) exp_xmax[v] = a % W;
        if (a / W < exp_ymin[v]) exp_ymin[v] = a / W;
        if (a / W > exp_ymax[v]) exp_ymax[v] = a / W;
      end
    end
    for (int b = 0; b <= NB; b++) begin
      if (exp_cnt[b] == 0) begin
        exp_xmin[b] = 0; exp_ymin[b] = 0;
      end
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    busy_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_valid"}, bin_valid, 0);
    checkOutput({tag, "_addr"}, edge_addr_read, 0);
    checkOutput({tag, "_id"}, bin_id, 0);
    checkOutput({tag, "_present"}, bin_present, 0);
    checkOutput({tag, "_count"}, bin_count, 0);
    checkOutput({tag, "_bounds"}, {bin_x_min, bin_x_max, bin_y_min, bin_y_max}, 0);
  endtask

  task automatic checkRecord(input int b, input string phase);
    string p;
    p = $sformatf("bin%0d_%s", b, phase);
    checkOutput({p, "_valid"}, bin_valid, 1);
    checkOutput({p, "_id"}, bin_id, b);
    checkOutput({p, "_present"}, bin_present, (exp_cnt[b] != 0) ? 1 : 0);
    checkOutput({p, "_count"}, bin_count, exp_cnt[b]);
    checkOutput({p, "_xmin"}, bin_x_min, exp_xmin[b]);
    checkOutput({p, "_xmax"}, bin_x_max, exp_xmax[b]);
    checkOutput({p, "_ymin"}, bin_y_min, exp_ymin[b]);
    checkOutput({p, "_ymax"}, bin_y_max, exp_ymax[b]);
  endtask

  // Walks the seven records; stall_bin is held off for stall_cycles,
  // rand_ready adds random back-pressure on every record.
  task automatic collectRecords(input int stall_bin, input int stall_cycles, input bit rand_ready);
    for (int b = 1; b <= NB; b++) begin
      int wc;
      int stalls;
      wc = 0;
      while (bin_valid !== 1'b1 && wc < N + 64) begin
        @(negedge clk);
        wc++;
      end
      checkOutput($sformatf("bin%0d_arrives", b), bin_valid, 1);
      if (bin_valid !== 1'b1) return;
      if (b > 1) checkOutput($sformatf("bin%0d_no_gap", b), wc, 0);
      stalls = (b == stall_bin) ? stall_cycles : (rand_ready ? $urandom_range(0, 3) : 0);
      for (int s = 0; s < stalls; s++) begin
        bin_ready = 1'b0;
        checkRecord(b, "stall");
        @(negedge clk);
      end
      bin_ready = 1'b1;
      checkRecord(b, "hs");
      @(negedge clk);
    end
    checkOutput("end_done", done, 1);
    checkOutput("end_busy", busy, 0);
    checkOutput("end_valid", bin_valid, 0);
  endtask

  task automatic runScan(input int stall_bin, input int stall_cycles, input bit rand_ready);
    computeExpected();
    applyStimulus();
    checkOutput("busy_after_start", busy, 1);
    checkOutput("done_after_start", done, 0);
    collectRecords(stall_bin, stall_cycles, rand_ready);
  endtask

  initial begin
    int wc;
    reset = 1'b1;
    start = 1'b0;
    bin_ready = 1'b0;
    clearMem();
    repeat (3) @(negedge clk);
    checkResetValues("por");
    reset = 1'b0;
    bin_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkResetValues("idle_ready_high");

    $display("[TB] all-zero image");
    runScan(0, 0, 1'b0);
    checkOutput("busy_span_ok", (busy_cnt >= N + 8 && busy_cnt <= N + 10) ? 1 : 0, 1);

    $display("[TB] three pixels of bin 3");
    clearMem();
    setPix(10, 20, 3); setPix(12, 21, 3); setPix(11, 25, 3);
    runScan(0, 0, 1'b0);

    $display("[TB] last pixel carries bin 5");
    clearMem();
    setPix(W - 1, H - 1, 5);
    runScan(0, 0, 1'b0);

    $display("[TB] back-pressure on record 2");
    randomImage(80);
    runScan(2, 4, 1'b0);

    $display("[TB] reset mid-scan and ignored start");
    randomImage(120);
    computeExpected();
    applyStimulus();
    wc = 0;
    while (edge_addr_read !== 19'd500 && wc < N) begin @(negedge clk); wc++; end
    checkOutput("reach_addr_500", edge_addr_read, 500);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_in_scan_addr", edge_addr_read, 501);
    checkOutput("start_in_scan_busy", busy, 1);
    wc = 0;
    while (edge_addr_read !== 19'd1000 && wc < N) begin @(negedge clk); wc++; end
    checkOutput("reach_addr_1000", edge_addr_read, 1000);
    reset = 1'b1;
    @(negedge clk);
    checkResetValues("mid_reset");
    reset = 1'b0;
    runScan(0, 0, 1'b0);

    $display("[TB] full row of bin 7");
    clearMem();
    for (int x = 0; x < W; x++) setPix(x, 30, 7);
    runScan(0, 0, 1'b0);

    $display("[TB] random images with random back-pressure");
    for (int r = 0; r < 3; r++) begin
      randomImage($urandom_range(20, 300));
      runScan(0, 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
